// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: holds fetched BTB predictions until execute resolves
// them in order, then produces BTB updates, fetch redirects and wrong-path flushes.
module branch_resolve_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [31:0]   push_pc,
  input  logic [31:0]   push_tgt,
  input  logic          push_hit,
  input  logic          resolve_valid,
  input  logic          resolve_taken,
  input  logic [31:0]   resolve_target,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ud_BTB_en,
  output logic [31:0]   pc_update,
  output logic [31:0]   real_bjpc,
  output logic          redirect,
  output logic [31:0]   redirect_pc,
  output logic          err_underflow,
  output logic [15:0]   mispredict_cnt
);

  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        hit;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            ud_btb_en_q, ud_btb_en_d;
  logic [31:0]     pc_update_q, pc_update_d;
  logic [31:0]     real_bjpc_q, real_bjpc_d;
  logic            redirect_q, redirect_d;
  logic [31:0]     redirect_pc_q, redirect_pc_d;
  logic            err_underflow_q, err_underflow_d;
  logic [15:0]     mispredict_cnt_q, mispredict_cnt_d;

  entry_t          head_entry;
  entry_t          wr_entry;
  logic            pop;
  logic            mispred;
  logic            push_ok;
  logic            btb_upd;

  assign head_entry = mem_q[head_q];
  assign wr_entry   = '{pc: push_pc, tgt: push_tgt, hit: push_hit};

  // Resolve decode and next-state computation
  always_comb begin
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    ud_btb_en_d      = 1'b0;
    pc_update_d      = pc_update_q;
    real_bjpc_d      = real_bjpc_q;
    redirect_d       = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    err_underflow_d  = err_underflow_q;
    mispredict_cnt_d = mispredict_cnt_q;

    pop     = resolve_valid && (count_q != CW'(0));
    mispred = pop && ((head_entry.hit != resolve_taken) ||
                      (resolve_taken && (head_entry.tgt != resolve_target)));
    btb_upd = pop && (resolve_taken ? (!head_entry.hit || (head_entry.tgt != resolve_target))
                                    : head_entry.hit);
    // A coinciding non-mispredicting pop frees the slot even when full
    push_ok = push && !mispred && ((count_q != CW'(DEPTH)) || pop);

    if (resolve_valid && (count_q == CW'(0))) begin
      err_underflow_d = 1'b1;
    end

    if (btb_upd) begin
      ud_btb_en_d = 1'b1;
      pc_update_d = head_entry.pc;
      real_bjpc_d = resolve_taken ? resolve_target : 32'h0;
    end

    if (mispred) begin
      redirect_d    = 1'b1;
      redirect_pc_d = resolve_taken ? resolve_target : (head_entry.pc + 32'd8);
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      if (mispredict_cnt_q != 16'hFFFF) begin
        mispredict_cnt_d = mispredict_cnt_q + 16'd1;
      end
    end else begin
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      if (push_ok) begin
        tail_d = tail_q + AW'(1);
      end
      if (push_ok && !pop) begin
        count_d = count_q + CW'(1);
      end else if (!push_ok && pop) begin
        count_d = count_q - CW'(1);
      end
    end

    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      full_q           <= 1'b0;
      ud_btb_en_q      <= 1'b0;
      pc_update_q      <= '0;
      real_bjpc_q      <= '0;
      redirect_q       <= 1'b0;
      redirect_pc_q    <= '0;
      err_underflow_q  <= 1'b0;
      mispredict_cnt_q <= '0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      full_q           <= full_d;
      ud_btb_en_q      <= ud_btb_en_d;
      pc_update_q      <= pc_update_d;
      real_bjpc_q      <= real_bjpc_d;
      redirect_q       <= redirect_d;
      redirect_pc_q    <= redirect_pc_d;
      err_underflow_q  <= err_underflow_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[tail_q] <= wr_entry;
    end
  end

  assign full           = full_q;
  assign count          = count_q;
  assign ud_BTB_en      = ud_btb_en_q;
  assign pc_update      = pc_update_q;
  assign real_bjpc      = real_bjpc_q;
  assign redirect       = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign err_underflow  = err_underflow_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule
